// File: rtl/logic_gate_unit_if.sv
// Operand/result handshake bundle for logic_gate_unit.
// master drives operands and consumes results; slave is the unit itself.
interface logic_gate_unit_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] F;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in_valid, op, A, B, out_ready,
      input  in_ready, F, out_valid
   );

   modport slave (
      input  in_valid, op, A, B, out_ready,
      output in_ready, F, out_valid
   );
endinterface

// File: rtl/logic_gate_unit.sv
// Pipelined WIDTH-bit logic unit (8 ops) with one output register stage and a
// built-in 32-vector truth-table sweep that captures a signature for self-test.
module logic_gate_unit #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   logic_gate_unit_if.slave    bus,
   input  logic                sweep_start,
   output logic                sweep_busy,
   output logic                sweep_done,
   output logic                sweep_fail,
   output logic [31:0]         signature
);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [4:0]       cnt;
   logic             accept;
   logic [WIDTH-1:0] sweep_res;

   function automatic logic [WIDTH-1:0] eval(input logic [2:0] f,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
      case (f)
         3'd0:    eval = a & b;
         3'd1:    eval = ~(a & b);
         3'd2:    eval = a | b;
         3'd3:    eval = ~(a | b);
         3'd4:    eval = a ^ b;
         3'd5:    eval = ~(a ^ b);
         3'd6:    eval = ~a;
         default: eval = a;
      endcase
   endfunction

   // Sweep has priority over a coincident beat, so a pending start blocks in_ready.
   assign bus.in_ready = (state == IDLE) && !sweep_start && (!bus.out_valid || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign sweep_busy   = (state == SWEEP);
   assign sweep_done   = (state == DONE);
   assign sweep_res    = eval(cnt[4:2], {WIDTH{cnt[1]}}, {WIDTH{cnt[0]}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sweep_start && !bus.out_valid) state_nxt = SWEEP;
         SWEEP:   if (cnt == 5'd31) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.F         <= '0;
         bus.out_valid <= 1'b0;
      end else if (accept) begin
         bus.F         <= eval(bus.op, bus.A, bus.B);
         bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

   // Signature bit index 4*op + {a,b} is simply cnt, since cnt = {op, a, b}.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         signature  <= '0;
         sweep_fail <= 1'b0;
      end else if (state == IDLE && state_nxt == SWEEP) begin
         cnt        <= '0;
         signature  <= '0;
         sweep_fail <= 1'b0;
      end else if (state == SWEEP) begin
         signature[cnt] <= sweep_res[0];
         sweep_fail     <= sweep_fail | (sweep_res != {WIDTH{sweep_res[0]}});
         cnt            <= cnt + 5'd1;
      end
   end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed self-checking bench for logic_gate_unit (WIDTH=8, plus a WIDTH=1 sweep instance).
module tb_logic_gate_unit;
   logic clk = 1'b0;
   logic rst;
   logic sweep_start, sweep_busy, sweep_done, sweep_fail;
   logic [31:0] signature;
   logic sweep_start1, sweep_busy1, sweep_done1, sweep_fail1;
   logic [31:0] signature1;
   int total = 0;
   int bad = 0;

   logic_gate_unit_if #(.WIDTH(8)) bus ();
   logic_gate_unit_if #(.WIDTH(1)) bus1 ();

   logic_gate_unit #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave), .sweep_start(sweep_start),
      .sweep_busy(sweep_busy), .sweep_done(sweep_done), .sweep_fail(sweep_fail),
      .signature(signature));

   logic_gate_unit #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave), .sweep_start(sweep_start1),
      .sweep_busy(sweep_busy1), .sweep_done(sweep_done1), .sweep_fail(sweep_fail1),
      .signature(signature1));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   function automatic logic [7:0] model(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
      case (f)
         3'd0: return a & b;
         3'd1: return ~(a & b);
         3'd2: return a | b;
         3'd3: return ~(a | b);
         3'd4: return a ^ b;
         3'd5: return ~(a ^ b);
         3'd6: return ~a;
         default: return a;
      endcase
   endfunction

   task automatic wait_done(input string tag);
      int n = 0;
      while (!sweep_done && n < 50) begin
         tick();
         n++;
      end
      check(tag, sweep_done, 1'b1);
      tick();
   endtask

   // Hand-written truth tables, bit {a,b}: AND NAND OR NOR XOR XNOR NOTA BUFA
   logic [3:0] tt [8] = '{4'h8, 4'h7, 4'hE, 4'h1, 4'h6, 4'h9, 4'h3, 4'hC};
   logic [7:0] va [4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
   logic [7:0] vb [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};

   initial begin
      logic [2:0] sop [16];
      logic [7:0] sa [16];
      logic [7:0] sb [16];
      logic [3:0] nib;
      int busy_n;

      // Reset with random inputs
      rst = 1'b1;
      bus.in_valid = 1'($urandom); bus.op = 3'($urandom); bus.A = 8'($urandom);
      bus.B = 8'($urandom); bus.out_ready = 1'($urandom); sweep_start = 1'b1;
      bus1.in_valid = 1'b0; bus1.op = '0; bus1.A = '0; bus1.B = '0; bus1.out_ready = 1'b1;
      sweep_start1 = 1'b0;
      tick(); tick();
      check("rst_F", bus.F, 8'h00);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_busy", sweep_busy, 1'b0);
      check("rst_done", sweep_done, 1'b0);
      check("rst_fail", sweep_fail, 1'b0);
      check("rst_sig", signature, 32'h0);
      check("rst_in_ready_start1", bus.in_ready, 1'b0);
      sweep_start = 1'b0;
      #1;
      check("rst_in_ready", bus.in_ready, 1'b1);
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Exhaustive single beats
      for (int f = 0; f < 8; f++) begin
         for (int v = 0; v < 4; v++) begin
            nib = tt[f];
            bus.in_valid = 1'b1; bus.op = 3'(f); bus.A = va[v]; bus.B = vb[v];
            #1;
            check("beat_in_ready", bus.in_ready, 1'b1);
            tick();
            bus.in_valid = 1'b0;
            check($sformatf("beat_F_op%0d_v%0d", f, v), bus.F, nib[v] ? 8'hFF : 8'h00);
            check("beat_out_valid", bus.out_valid, 1'b1);
         end
      end
      tick();
      check("drain_out_valid", bus.out_valid, 1'b0);

      // Back-pressure
      bus.in_valid = 1'b1; bus.op = 3'd4; bus.A = 8'h0F; bus.B = 8'h33; bus.out_ready = 1'b0;
      tick();
      bus.A = 8'hAA; bus.B = 8'h55; bus.op = 3'd0;
      for (int i = 0; i < 5; i++) begin
         check("bp_F", bus.F, 8'h3C);
         check("bp_out_valid", bus.out_valid, 1'b1);
         check("bp_in_ready", bus.in_ready, 1'b0);
         tick();
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      tick();
      check("bp_single_transfer", bus.out_valid, 1'b0);
      check("bp_F_kept", bus.F, 8'h3C);

      // Back-to-back streaming
      for (int i = 0; i < 16; i++) begin
         sop[i] = 3'($urandom); sa[i] = 8'($urandom); sb[i] = 8'($urandom);
      end
      for (int i = 0; i < 16; i++) begin
         bus.in_valid = 1'b1; bus.op = sop[i]; bus.A = sa[i]; bus.B = sb[i];
         #1;
         check("stream_in_ready", bus.in_ready, 1'b1);
         tick();
         check($sformatf("stream_F_%0d", i), bus.F, model(sop[i], sa[i], sb[i]));
         check("stream_out_valid", bus.out_valid, 1'b1);
      end
      bus.in_valid = 1'b0;
      tick();

      // Full sweep on both widths
      sweep_start = 1'b1; sweep_start1 = 1'b1;
      #1;
      check("sweep_in_ready", bus.in_ready, 1'b0);
      tick();
      sweep_start = 1'b0; sweep_start1 = 1'b0;
      busy_n = 0;
      while (sweep_busy && busy_n < 40) begin
         busy_n++;
         tick();
      end
      check("sweep_busy_cycles", busy_n, 32);
      check("sweep_done_pulse", sweep_done, 1'b1);
      check("sweep_busy_in_done", sweep_busy, 1'b0);
      check("sweep_sig", signature, 32'hC3961E78);
      check("sweep_fail", sweep_fail, 1'b0);
      check("sweep_done_w1", sweep_done1, 1'b1);
      check("sweep_sig_w1", signature1, 32'hC3961E78);
      check("sweep_fail_w1", sweep_fail1, 1'b0);
      check("sweep_out_valid_untouched", bus.out_valid, 1'b0);
      tick();
      check("sweep_done_one_cycle", sweep_done, 1'b0);
      check("sweep_in_ready_after", bus.in_ready, 1'b1);

      // sweep_start while a result is pending
      bus.in_valid = 1'b1; bus.op = 3'd2; bus.A = 8'h12; bus.B = 8'h40; bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0; sweep_start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("pend_sweep_ignored", sweep_busy, 1'b0);
         check("pend_F", bus.F, 8'h52);
      end
      bus.out_ready = 1'b1;
      tick();
      check("pend_drained", bus.out_valid, 1'b0);
      check("pend_still_idle", sweep_busy, 1'b0);
      tick();
      check("pend_sweep_started", sweep_busy, 1'b1);
      sweep_start = 1'b0;
      wait_done("pend_sweep_done");

      // Coincident sweep_start and beat
      bus.in_valid = 1'b1; bus.op = 3'd7; bus.A = 8'h99; sweep_start = 1'b1;
      #1;
      check("coinc_in_ready", bus.in_ready, 1'b0);
      tick();
      sweep_start = 1'b0;
      check("coinc_busy", sweep_busy, 1'b1);
      check("coinc_no_beat", bus.out_valid, 1'b0);
      check("coinc_in_ready_busy", bus.in_ready, 1'b0);
      bus.in_valid = 1'b0;
      wait_done("coinc_sweep_done");

      // Reset mid-sweep
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      repeat (10) tick();
      check("abort_busy_before", sweep_busy, 1'b1);
      rst = 1'b1;
      bus.in_valid = 1'($urandom); bus.A = 8'($urandom); bus.B = 8'($urandom);
      #1;
      check("abort_busy", sweep_busy, 1'b0);
      check("abort_sig", signature, 32'h0);
      check("abort_in_ready", bus.in_ready, 1'b1);
      tick();
      rst = 1'b0; bus.in_valid = 1'b0;
      begin
         int seen = 0;
         for (int i = 0; i < 40; i++) begin
            if (sweep_done) seen = 1;
            tick();
         end
         check("abort_no_done", seen, 0);
      end
      check("abort_sig_after", signature, 32'h0);
      check("abort_fail_after", sweep_fail, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/logic_gate_unit.md
# logic_gate_unit

Parametrised, pipelined bitwise logic unit: the next generation of the single-bit NAND gate models. It evaluates one of eight two-input logic functions on WIDTH-bit operands and registers the result behind a valid/ready handshake. It also contains a built-in truth-table sweep engine. The sweep drives the standard 00/01/10/11 stimulus through every operation and captures a 32-bit signature, so the block can self-check in-system.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts beat this cycle.
- op  input  3  operation select, sampled with the beat:
  - 0 AND, 1 NAND, 2 OR, 3 NOR
  - 4 XOR, 5 XNOR, 6 NOT A, 7 BUF A
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; ignored for op 6/7.
- F  output  WIDTH  registered result.
- out_valid  output  1  F holds an unconsumed result.
- out_ready  input  1  downstream accepts F.
- sweep_start  input  1  request truth-table sweep (level sampled).
- sweep_busy  output  1  sweep in progress.
- sweep_done  output  1  one-cycle pulse at sweep completion.
- sweep_fail  output  1  set if any sweep result was not bit-uniform across WIDTH.
- signature  output  32  captured truth tables; nibble k = op k.

## Operation
- Data path: single output register stage. F <= func(op, A, B) on an accepted beat, where accept = in_valid && in_ready.
- in_ready = (state == IDLE) && !sweep_start && (!out_valid || out_ready). This gives full throughput with a ready-through path.
- out_valid set on accept; cleared when out_ready && !accept. F and out_valid are held stable while out_valid && !out_ready.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when sweep_start && !out_valid. sweep_start while out_valid=1 is ignored and must be held by the requester.
  - SWEEP runs a 5-bit counter cnt = 0..31. The vector for each cnt is:
    - op = cnt[4:2]
    - A = {WIDTH{cnt[1]}}
    - B = {WIDTH{cnt[0]}}
  - Each SWEEP cycle the sweep result R is evaluated combinationally. signature[4*cnt[4:2] + cnt[1:0]] <= R[0]. sweep_fail <= sweep_fail | (R != {WIDTH{R[0]}}).
  - SWEEP -> DONE when cnt == 31; DONE -> IDLE unconditionally after one cycle.
- On entering SWEEP, signature and sweep_fail clear to 0.
- signature and sweep_fail then hold until the next sweep start or reset.
- The sweep does not touch F or out_valid. No handshake beats are accepted during SWEEP or DONE.
- A simultaneous sweep_start and in_valid in IDLE with an empty pipe gives priority to the sweep; the beat is not accepted.

## Timing
- Reset values: F=0, out_valid=0, sweep_busy=0, sweep_done=0, sweep_fail=0, signature=0, state=IDLE, cnt=0.
- in_ready is combinational. Under reset it is 1 when sweep_start=0.
- Data latency: result visible on F, with out_valid=1, the cycle after the accepting edge.
- Sweep cycle counts, with edge 0 = the edge that samples sweep_start:
  - sweep_busy = 1 for 32 cycles after edge 0.
  - sweep_done = 1 for exactly the following cycle; sweep_busy = 0 during it.
  - in_ready returns to 1 the cycle after DONE.
- Reset asserted mid-sweep aborts immediately: no sweep_done pulse, and signature is 0.
- Reset while out_valid=1 discards the pending result.

## Test plan
- Reset: assert rst with random inputs -> all outputs at reset values, and in_ready=1 once sweep_start=0.
- Exhaustive single beat, WIDTH=8, out_ready=1: op=1, A/B = 00/00, 00/FF, FF/00, FF/FF -> F = FF, FF, FF, 00, each one cycle after accept. Repeat for all 8 ops against their truth tables.
- Back-pressure: accept A=0x0F, B=0x33, op=4, then hold out_ready=0 for 5 cycles -> F=0x3C stable, out_valid=1, in_ready=0. Release -> one transfer only, no duplicate.
- Back-to-back streaming: 16 random beats with out_ready=1 -> 16 results in order at 1 beat/cycle.
- Sweep: pulse sweep_start with an empty pipe -> sweep_busy=1 for 32 cycles, then a sweep_done pulse with signature=0xC3961E78 and sweep_fail=0. Repeat with WIDTH=1 -> same signature.
- Corner cases:
  - sweep_start with out_valid=1, out_ready=0 -> ignored until drained.
  - sweep_start and in_valid together -> the sweep starts and in_ready=0.
  - rst at cycle 10 of a sweep -> no sweep_done, and signature=0.
